// File: rtl/touch_panel_spi_slave.sv
// Mode-0 SPI responder with an Avalon-style register port for the touch-panel subsystem.
// Define TOUCH_PANEL_SPI_SLAVE_EOP_EN to enable end-of-packet detection.
module touch_panel_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [15:0] CTRL_MASK = 16'h03D8;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    state_t      state;
    logic [2:0]  bitcnt;
    logic        reload;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_holding;
    logic [7:0]  tx_holding;
    logic        primed;
    logic        rrdy;
    logic        trdy;
    logic        roe;
    logic        toe;
    logic        eop;
    logic [15:0] eop_val;
    logic [15:0] ctrl;
    logic        rd_q;
    logic        wr_q;

    logic        rd_stb;
    logic        wr_stb;
    logic        rx_rd;
    logic        tx_wr;
    logic        st_wr;
    logic        ctl_wr;
    logic        eop_wr;
    logic        byte_done;
    logic        tx_load;
    logic        tmt;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_next;
    logic [15:0] status;

    // Synchronizers are left unreset so a select already held low across
    // reset cannot look like a fresh SS_n fall afterwards.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
        ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        sclk_d    <= sclk_sync[SYNC_STAGES-1];
        ss_d      <= ss_sync[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    assign rd_stb = spi_select & ~read_n & ~rd_q;
    assign wr_stb = spi_select & ~write_n & ~wr_q;
    assign rx_rd  = rd_stb & (mem_addr == 3'd0);
    assign tx_wr  = wr_stb & (mem_addr == 3'd1);
    assign st_wr  = wr_stb & (mem_addr == 3'd2);
    assign ctl_wr = wr_stb & (mem_addr == 3'd3);
    assign eop_wr = wr_stb & (mem_addr == 3'd6);

    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign tx_next   = primed ? tx_holding : 8'h00;
    assign byte_done = (state == ACTIVE) & ~ss_rise & sclk_rise
                     & (bitcnt == 3'd7);
    assign tx_load   = ((state == IDLE) & ss_fall)
                     | ((state == ACTIVE) & ~ss_rise & sclk_fall & reload);
    assign tmt       = ~primed & (state == IDLE);

    assign status = {6'b0, eop, roe | toe, rrdy, trdy, tmt, toe, roe, 3'b0};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            reload      <= 1'b0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            rx_holding  <= 8'h00;
            tx_holding  <= 8'h00;
            primed      <= 1'b0;
            rrdy        <= 1'b0;
            trdy        <= 1'b1;
            roe         <= 1'b0;
            toe         <= 1'b0;
            ctrl        <= 16'h0000;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            MISO        <= 1'b0;
            data_to_cpu <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            rd_q <= spi_select & ~read_n;
            wr_q <= spi_select & ~write_n;

            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= ACTIVE;
                        bitcnt   <= 3'd0;
                        reload   <= 1'b0;
                        tx_shift <= tx_next;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state  <= IDLE;
                        bitcnt <= 3'd0;
                        reload <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bitcnt   <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7)
                                reload <= 1'b1;
                        end
                        if (sclk_fall) begin
                            if (reload) begin
                                tx_shift <= tx_next;
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // primed and trdy stay complementary, so a load and an accepted
            // write can never both act in one cycle.
            if (tx_load && primed) begin
                primed <= 1'b0;
                trdy   <= 1'b1;
            end else if (tx_wr && trdy) begin
                tx_holding <= data_from_cpu[7:0];
                primed     <= 1'b1;
                trdy       <= 1'b0;
            end

            if (byte_done)
                rx_holding <= rx_byte;

            if (byte_done)
                rrdy <= 1'b1;
            else if (rx_rd || st_wr)
                rrdy <= 1'b0;

            if (byte_done && rrdy && !rx_rd)
                roe <= 1'b1;
            else if (st_wr)
                roe <= 1'b0;

            if (tx_wr && !trdy)
                toe <= 1'b1;
            else if (st_wr)
                toe <= 1'b0;

            if (ctl_wr)
                ctrl <= data_from_cpu & CTRL_MASK;

            MISO <= (state == ACTIVE) ? tx_shift[7] : 1'b0;

            if (rd_stb) begin
                unique case (mem_addr)
                    3'd0:    data_to_cpu <= {8'h00, rx_holding};
                    3'd2:    data_to_cpu <= status;
                    3'd3:    data_to_cpu <= ctrl;
                    3'd6:    data_to_cpu <= eop_val;
                    default: data_to_cpu <= 16'h0000;
                endcase
            end

            irq <= (eop & ctrl[9]) | ((roe | toe) & ctrl[8])
                 | (rrdy & ctrl[7]) | (trdy & ctrl[6])
                 | (toe & ctrl[4]) | (roe & ctrl[3]);
        end
    end

`ifdef TOUCH_PANEL_SPI_SLAVE_EOP_EN
    logic eop_set;

    assign eop_set = (byte_done & (rx_byte == eop_val[7:0]))
                   | (tx_wr & (data_from_cpu[7:0] == eop_val[7:0]));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            eop     <= 1'b0;
            eop_val <= 16'h0000;
        end else begin
            if (eop_set)
                eop <= 1'b1;
            else if (st_wr)
                eop <= 1'b0;
            if (eop_wr)
                eop_val <= data_from_cpu;
        end
    end
`else
    assign eop     = 1'b0;
    assign eop_val = 16'h0000;
`endif

    assign dataavailable = rrdy;
    assign readyfordata  = trdy;
    assign endofpacket   = eop;

endmodule

// File: tb/tb_touch_panel_spi_slave.sv
// Scoreboard bench for touch_panel_spi_slave: bit-banged mode-0 master plus CPU bus tasks.
module tb_touch_panel_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0000;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;
    logic        endofpacket;

    int checks = 0;
    int errors = 0;

    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];
    bit         exp_rrdy = 1'b0;

`ifdef TOUCH_PANEL_SPI_SLAVE_EOP_EN
    localparam bit EOP_ON = 1'b1;
`else
    localparam bit EOP_ON = 1'b0;
`endif

    touch_panel_spi_slave dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SCLK          (SCLK),
        .SS_n          (SS_n),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .irq           (irq),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata),
        .endofpacket   (endofpacket)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select    = 1'b1;
        write_n       = 1'b0;
        mem_addr      = a;
        data_from_cpu = d;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0;
        write_n    = 1'b1;
        if (a == 3'd2)
            exp_rrdy = 1'b0;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1;
        read_n     = 1'b0;
        mem_addr   = a;
        @(negedge clk);
        d = data_to_cpu;
        @(negedge clk);
        spi_select = 1'b0;
        read_n     = 1'b1;
        if (a == 3'd0)
            exp_rrdy = 1'b0;
    endtask

    task automatic rd_status(input logic [15:0] exp);
        logic [15:0] d;
        cpu_rd(3'd2, d);
        chk("status", d, exp);
    endtask

    task automatic rd_rx();
        logic [15:0] d;
        cpu_rd(3'd0, d);
        if (rx_q.size() == 0)
            chk("rx_q_empty", 16'd1, 16'd0);
        else
            chk("rxdata", d, {8'h00, rx_q.pop_front()});
    endtask

    task automatic ss_lo();
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_hi();
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master at clk/16: MOSI set in the low phase, MISO sampled at rise.
    task automatic spi_byte(input logic [7:0] b, input int nbits);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            got  = {got[6:0], MISO};
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        if (nbits == 8) begin
            if (exp_rrdy)
                rx_q[rx_q.size()-1] = b;
            else
                rx_q.push_back(b);
            exp_rrdy = 1'b1;
            if (miso_q.size() == 0)
                chk("miso_q_empty", 16'd1, 16'd0);
            else
                chk("miso_byte", {8'h00, got}, {8'h00, miso_q.pop_front()});
        end
    endtask

    initial begin
        logic [15:0] d;

        repeat (3) @(negedge clk);
        chk("rst_miso", {15'd0, MISO}, 16'd0);
        chk("rst_dout", data_to_cpu, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_davail", {15'd0, dataavailable}, 16'd0);
        chk("rst_rfd", {15'd0, readyfordata}, 16'd1);
        chk("rst_eop", {15'd0, endofpacket}, 16'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        rd_status(16'h0060);

        // single exchange with RRDY interrupt
        cpu_wr(3'd3, 16'h0080);
        cpu_wr(3'd1, 16'h00A5);
        miso_q.push_back(8'hA5);
        chk("rfd_after_wr", {15'd0, readyfordata}, 16'd0);
        rd_status(16'h0000);
        ss_lo();
        spi_byte(8'h3C, 8);
        ss_hi();
        chk("davail_set", {15'd0, dataavailable}, 16'd1);
        chk("irq_rrdy", {15'd0, irq}, 16'd1);
        rd_status(16'h00E0);
        rd_rx();
        chk("davail_clr", {15'd0, dataavailable}, 16'd0);
        chk("irq_clr", {15'd0, irq}, 16'd0);
        cpu_wr(3'd3, 16'h0000);

        // receive overrun, then status write clears
        miso_q.push_back(8'h00);
        ss_lo();
        spi_byte(8'h11, 8);
        ss_hi();
        miso_q.push_back(8'h00);
        ss_lo();
        spi_byte(8'h22, 8);
        ss_hi();
        rd_status(16'h01E8);
        cpu_wr(3'd2, 16'h0000);
        rd_status(16'h0060);
        rd_rx();

        // transmit overrun and underrun in one select window
        cpu_wr(3'd1, 16'h005A);
        cpu_wr(3'd1, 16'h0077);
        rd_status(16'h0110);
        miso_q.push_back(8'h5A);
        miso_q.push_back(8'h00);
        ss_lo();
        spi_byte(8'h33, 8);
        spi_byte(8'h44, 8);
        ss_hi();
        rd_status(16'h01F8);
        cpu_wr(3'd2, 16'h0000);
        rd_rx();
        chk("rfd_after_load", {15'd0, readyfordata}, 16'd1);

        // abort after five rises, then a clean byte
        ss_lo();
        spi_byte(8'hFF, 5);
        ss_hi();
        chk("abort_davail", {15'd0, dataavailable}, 16'd0);
        rd_status(16'h0060);
        miso_q.push_back(8'h00);
        ss_lo();
        spi_byte(8'h81, 8);
        ss_hi();
        rd_rx();

        // end-of-packet match
        cpu_wr(3'd6, 16'h000D);
        cpu_rd(3'd6, d);
        chk("eop_val", d, EOP_ON ? 16'h000D : 16'h0000);
        miso_q.push_back(8'h00);
        ss_lo();
        spi_byte(8'h0D, 8);
        ss_hi();
        chk("endofpacket", {15'd0, endofpacket}, {15'd0, EOP_ON});
        rd_status(EOP_ON ? 16'h02E0 : 16'h00E0);
        rd_rx();
        cpu_wr(3'd2, 16'h0000);
        chk("eop_clr", {15'd0, endofpacket}, 16'd0);
        rd_status(16'h0060);

        if (miso_q.size() != 0 || rx_q.size() != 0)
            chk("queues_drained", 16'd1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
